// File: rtl/clk_mgr_pkg.sv
// Shared definitions for the clock-domain manager:
// FSM state codes and the state enum.
package clk_mgr_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  typedef enum logic [1:0] {
    WAIT_LOCK = ST_WAIT_LOCK,
    HOLD      = ST_HOLD,
    RELEASE   = ST_RELEASE,
    RUN       = ST_RUN
  } mgr_state_e;

endpackage

// File: rtl/clk_ce_div.sv
// Per-channel divider: wrapping counter, div/phase regs
// and a registered clock-enable strobe.
module clk_ce_div #(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             upd,
  input  logic [DIV_W-1:0] upd_div,
  input  logic [DIV_W-1:0] upd_phase,
  output logic             wrap,
  output logic             ce
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] phase_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;
  logic [DIV_W-1:0] eff;
  logic             bypass;

  // div of 0 or 1 means "every cycle"
  assign bypass = div_q < DIV_W'(2);
  assign last   = div_q - DIV_W'(1);
  assign eff    = (phase_q > last) ? last : phase_q;
  assign wrap   = en && (bypass || cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_q   <= DIV_W'(DEF_DIV);
      phase_q <= '0;
      ce      <= 1'b0;
    end else begin
      ce <= en && (bypass || cnt == eff);
      if (!en || wrap) cnt <= '0;
      else             cnt <= cnt + DIV_W'(1);
      if (upd) begin
        div_q   <= upd_div;
        phase_q <= upd_phase;
      end
    end
  end

endmodule

// File: rtl/clk_domain_mgr.sv
// Clock-domain manager: lock sync, staggered reset
// release FSM, config slot and per-channel dividers.
module clk_domain_mgr
  import clk_mgr_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  parameter int RST_HOLD = 16,
  parameter int STAGGER  = 4,
  parameter int DEF_DIV  = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              pll_locked,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              clr_lost,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic [1:0]        state,
  output logic              lock_lost
);

  localparam int HW       = $clog2(RST_HOLD + 1);
  localparam int REL_MAX  = (NUM_CH - 1) * STAGGER;
  localparam int RW       = $clog2(REL_MAX + 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [RW-1:0] REL_LAST  = RW'(REL_MAX);
  localparam logic [3:0]    NCH       = 4'(NUM_CH);

  logic sync1;
  logic lock;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      lock  <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lock  <= sync1;
    end
  end

  mgr_state_e    st;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rel_cnt;
  logic [RW-1:0] rel_inc;

  assign state   = st;
  assign rel_inc = rel_cnt + RW'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st        <= WAIT_LOCK;
      hold_cnt  <= '0;
      rel_cnt   <= '0;
      rst_n_out <= '0;
      lock_lost <= 1'b0;
    end else begin
      // a loss seen in the same cycle as clr_lost wins
      if (!lock && (st == RELEASE || st == RUN))
        lock_lost <= 1'b1;
      else if (clr_lost)
        lock_lost <= 1'b0;

      if (!lock) begin
        st        <= WAIT_LOCK;
        rst_n_out <= '0;
      end else begin
        unique case (st)
          WAIT_LOCK: begin
            st       <= HOLD;
            hold_cnt <= '0;
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              st           <= RELEASE;
              rel_cnt      <= '0;
              rst_n_out[0] <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          RELEASE: begin
            if (rel_cnt == REL_LAST) begin
              st <= RUN;
            end else begin
              rel_cnt <= rel_inc;
              for (int i = 1; i < NUM_CH; i++)
                if (rel_inc == RW'(i * STAGGER))
                  rst_n_out[i] <= 1'b1;
            end
          end
          RUN: begin
          end
        endcase
      end
    end
  end

  logic              pend_v;
  logic [2:0]        pend_ch;
  logic [DIV_W-1:0]  pend_div;
  logic [DIV_W-1:0]  pend_phase;
  logic              pend_ok;
  logic              hit_wrap;
  logic              apply;
  logic              run_en;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] upd;

  assign cfg_ready = !pend_v;
  assign pend_ok   = {1'b0, pend_ch} < NCH;
  assign run_en    = (st == RUN) && lock;
  // out-of-range channels drain at once and match no upd bit
  assign apply     = pend_v && (!pend_ok || st != RUN || hit_wrap);

  always_comb begin
    hit_wrap = 1'b0;
    upd      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend_ch == 3'(i)) begin
        hit_wrap = wrap[i];
        upd[i]   = apply;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_v     <= 1'b0;
      pend_ch    <= '0;
      pend_div   <= '0;
      pend_phase <= '0;
    end else if (apply) begin
      pend_v <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      pend_v     <= 1'b1;
      pend_ch    <= cfg_ch;
      pend_div   <= cfg_div;
      pend_phase <= cfg_phase;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_ce_div #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_div (
      .clk      (CLK),
      .rst_n    (RST_N),
      .en       (run_en),
      .upd      (upd[g]),
      .upd_div  (pend_div),
      .upd_phase(pend_phase),
      .wrap     (wrap[g]),
      .ce       (ce[g])
    );
  end

endmodule

// File: doc/clk_domain_mgr.md
CLK_DOMAIN_MGR -- requirements
Module: clk_domain_mgr

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of derived clock-enable/reset channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 16, width of divider and phase fields.
REQ-003 SHALL have parameter RST_HOLD, default 16, cycles of stable lock required before the first reset release (>=1).
REQ-004 SHALL have parameter STAGGER, default 4, cycles between successive channel reset releases (>=1).
REQ-005 SHALL have parameter DEF_DIV, default 1, divider value loaded into every channel at reset.
REQ-006 Ports: CLK  in  1  single system clock; all logic is on its rising edge.
REQ-007 Ports: RST_N  in  1  reset, asynchronous assert and active-low.
REQ-008 Ports: pll_locked  in  1  PLL lock, asynchronous to CLK.
REQ-009 Ports: cfg_valid  in  1  config request; cfg_ready  out  1  config accept.
REQ-010 Ports: cfg_ch  in  3  channel index; cfg_div  in  DIV_W  divider; cfg_phase  in  DIV_W  strobe phase.
REQ-011 Ports: clr_lost  in  1  clears the sticky lock-lost flag.
REQ-012 Ports: ce  out  NUM_CH  per-channel one-cycle clock-enable strobes.
REQ-013 Ports: rst_n_out  out  NUM_CH  per-channel active-low synchronous resets.
REQ-014 Ports: state  out  2  FSM state code; lock_lost  out  1  sticky lock-loss flag.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchroniser; "lock" below means the synchronised value.
REQ-016 FSM states: WAIT_LOCK=0, HOLD=1, RELEASE=2, RUN=3.
REQ-017 WAIT_LOCK -> HOLD when lock=1; the hold counter is cleared on entry.
REQ-018 HOLD -> RELEASE after RST_HOLD consecutive cycles with lock=1.
REQ-019 In RELEASE, channel i SHALL deassert rst_n_out[i] (set to 1) exactly i*STAGGER cycles after entering RELEASE; once the last channel is released, the FSM moves to RUN on the following cycle.
REQ-020 In any state, lock=0 SHALL move the FSM to WAIT_LOCK next cycle, drive all rst_n_out to 0, and zero all ce; if the prior state was RELEASE or RUN, lock_lost SHALL be set.
REQ-021 lock_lost SHALL clear on clr_lost=1 unless a lock loss occurs in the same cycle, in which case set wins.
REQ-022 Per channel: counter cnt[i] counts 0..div[i]-1 and wraps; it runs only in RUN and is 0 on RUN entry.
REQ-023 ce[i] SHALL be 1 for one cycle when cnt[i]==eff_phase[i], where eff_phase = min(phase, div-1).
REQ-024 div of 0 or 1 SHALL make ce[i] constantly 1 while in RUN.
REQ-025 ce SHALL be registered: the strobe appears the cycle after the matching count.
REQ-026 Config: a transfer occurs when cfg_valid and cfg_ready are both 1; it is captured into a single pending slot, and cfg_ready=0 while the slot is full.
REQ-027 A pending update SHALL apply when the target channel wraps (cnt==div-1), or immediately if the FSM is not in RUN; cfg_ready returns to 1 the cycle after it applies.
REQ-028 cfg_ch >= NUM_CH SHALL be accepted and discarded without changing any channel.
REQ-029 Lock loss SHALL NOT discard the pending slot or the programmed div/phase values.

Reset
REQ-030 While RST_N=0, outputs SHALL be: ce=0, rst_n_out=0, state=WAIT_LOCK, lock_lost=0, cfg_ready=1.
REQ-031 While RST_N=0: synchroniser flops=0, counters=0, div=DEF_DIV, phase=0, pending slot empty.
REQ-032 Assertion of RST_N mid-operation SHALL take effect immediately (asynchronously) regardless of FSM state.

Structure
REQ-033 A shared package clk_mgr_pkg SHALL hold the FSM state enum and the state encoding constants.
REQ-034 The per-channel divider (counter, div/phase registers, strobe) SHALL be a sub-module clk_ce_div, instantiated NUM_CH times.
REQ-035 The synchroniser, FSM, reset stagger logic and config slot SHALL reside in clk_domain_mgr.

Verification
REQ-036 Defaults; pll_locked rises at cycle 10 -> rst_n_out[0] rises at cycle 10+2+16 (+/-1 per REQ-019 boundary), rst_n_out[1..3] follow at +4, +8, +12 cycles; state=3 one cycle after the last release.
REQ-037 In RUN, cfg ch1 div=5 phase=2 -> after the next wrap, ce[1] pulses every 5 cycles, one cycle after cnt==2; cfg_ready is 0 until the update applies.
REQ-038 cfg div=4 phase=9 -> ce pulses at cnt==3; cfg div=0 -> ce held at 1 in RUN.
REQ-039 Drop pll_locked in RUN -> within 3 cycles all rst_n_out=0, ce=0, lock_lost=1; clr_lost asserted together with a new lock loss -> lock_lost stays 1.
REQ-040 Assert RST_N=0 during RELEASE -> all outputs reach their reset values without waiting for a clock edge; cfg_ch=7 with NUM_CH=4 -> accepted, no channel changes.
